rr_mux_arbiter: RTL and testbench
=================================

// Module: rr_mux_arbiter
// PURPOSE
//  Round-robin arbiter that shares one N-bit 4:1 multiplexer datapath between
//  four requesters (A..D). It grants one requester at a time and drives the mux
//  select S. It registers the selected data onto Y with a valid strobe.
//  It sits in front of NBit_4x1_Multiplexer and owns S; no other block drives S.
// PARAMETERS
//  N         4   data width of each requester input and of Y
//  MAX_HOLD  4   max consecutive cycles one owner keeps the grant while others
//                wait; legal range 1..15
// PORTS
//  clk    in   1        rising-edge clock
//  nrst   in   1        asynchronous, active-low reset
//  req    in   4        request lines; req[0]=A, req[1]=B, req[2]=C, req[3]=D
//  A      in   N        requester 0 data
//  B      in   N        requester 1 data
//  C      in   N        requester 2 data
//  D      in   N        requester 3 data
//  gnt    out  4        one-hot grant, registered; 0 when idle
//  S      out  2        mux select = index of current/last owner, registered
//  Y      out  N        registered mux output
//  valid  out  1        Y holds data sampled from an owner
// BEHAVIOUR
//  - Only one clock. Reset is asynchronous and active-low.
//  - nrst=0 forces, immediately and independent of clk:
//    state=IDLE, gnt=0000, S=00, Y=0, valid=0, hold_cnt=0, last=3.
//    last=3 gives A first priority after reset.
//  - Reset mid-grant aborts the transfer with no further valid cycles.
//  - States:
//    - IDLE: gnt=0.
//    - GRANT: gnt=onehot(S).
//  - Round-robin pick: search from (last+1) mod 4 upward, with wrap-around.
//    Take the first index with req=1.
//  - IDLE, req!=0 at edge: next = GRANT, S=pick, gnt=onehot(pick), hold_cnt=1,
//    last=pick.
//  - IDLE, req==0: stay in IDLE; S keeps its last value.
//  - GRANT, owner o=S, evaluated at each edge, in priority order:
//    1. req[o]=0 and other req pending: re-grant pick in the same edge.
//       No idle bubble. hold_cnt=1.
//    2. req[o]=0 and no other req: go to IDLE; gnt=0; S holds.
//    3. hold_cnt==MAX_HOLD and other req pending: re-grant pick in the same
//       edge. hold_cnt=1.
//    4. hold_cnt==MAX_HOLD and no other req: keep o; hold_cnt=1.
//    5. Otherwise: keep o; hold_cnt+1.
//  - Starvation bound: a waiting requester is granted within
//    3*MAX_HOLD cycles.
//  - Datapath: at every edge where gnt!=0 before the edge,
//    Y<=mux(S){A,B,C,D} and valid<=1.
//  - Where gnt==0 before the edge, valid<=0 and Y holds.
//  - Latency: data present at the edge that ends an owner's cycle appears on Y
//    the following cycle, i.e. 1 clk.
//  - Requesters hold their data stable while granted. The arbiter never
//    retracts a grant except by rules 1-4 or by reset.
//  - MAX_HOLD=1: with all requesters active, the grant rotates every cycle.
//  - hold_cnt width is 4 bits. It never exceeds MAX_HOLD.
// TESTING
//  1. Reset: nrst=0 mid-run -> gnt=0, S=00, Y=0, valid=0 without waiting for
//     clk; after release with req=0000, outputs stay idle.
//  2. Single request: req=0100, C=4'b0010 -> gnt=0100, S=10 the next edge;
//     Y=0010, valid=1 one edge later; it keeps the grant past MAX_HOLD
//     (rule 4).
//  3. All requesting, MAX_HOLD=4: req=1111 from reset -> grant order
//     A,B,C,D,A, with 4 cycles each.
//  4. Early release: A owns, req drops to 1010 after 2 cycles -> grant moves
//     to B (then D next turn) in the same edge, with no gnt=0 cycle.
//  5. Wrap-around: last=D, req=1001 -> next grant A, not D.
//  6. MAX_HOLD=1, req=0101 -> gnt alternates 0001, 0100 every cycle;
//     Y alternates A, C with valid held at 1.

Source files
------------

// File: rtl/rr_mux_arbiter_if.sv
// rr_mux_arbiter_if: requester/mux bundle shared by the arbiter and its requesters
interface rr_mux_arbiter_if #(parameter int N = 4);
    logic [3:0]   req;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] C;
    logic [N-1:0] D;
    logic [3:0]   gnt;
    logic [1:0]   S;
    logic [N-1:0] Y;
    logic         valid;
    modport slave (input req, A, B, C, D, output gnt, S, Y, valid);
    modport master (output req, A, B, C, D, input gnt, S, Y, valid);
endinterface

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin owner of a 4:1 mux select with bounded hold and registered output
module rr_mux_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic            clk,
    input  logic            nrst,
    rr_mux_arbiter_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;
    localparam logic [3:0] HMAX = 4'(MAX_HOLD);
    state_t       r_state, w_state;
    logic [1:0]   r_s, w_s, r_last, w_last, w_pick;
    logic [3:0]   r_hold, w_hold, r_gnt, w_others;
    logic [N-1:0] r_y;
    logic         r_valid;
    // Descending scan so the nearest requester after last wins; in GRANT last equals the owner.
    always_comb begin
        w_pick = r_last;
        for (int k = 4; k >= 1; k--)
            if (bus.req[r_last + 2'(k)]) w_pick = r_last + 2'(k);
    end
    assign w_others = bus.req & ~(4'b1 << r_s);
    always_comb begin
        w_state = r_state;
        w_s     = r_s;
        w_last  = r_last;
        w_hold  = r_hold;
        if (r_state == IDLE) begin
            if (|bus.req) begin
                w_state = GRANT;
                w_s     = w_pick;
                w_last  = w_pick;
                w_hold  = 4'd1;
            end
        end else if (|w_others && (!bus.req[r_s] || r_hold == HMAX)) begin
            w_s    = w_pick;
            w_last = w_pick;
            w_hold = 4'd1;
        end else if (!bus.req[r_s]) begin
            w_state = IDLE;
        end else begin
            w_hold = (r_hold == HMAX) ? 4'd1 : r_hold + 4'd1;
        end
    end
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
            r_s     <= 2'd0;
            r_last  <= 2'd3;
            r_hold  <= 4'd0;
            r_gnt   <= 4'd0;
            r_y     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state;
            r_s     <= w_s;
            r_last  <= w_last;
            r_hold  <= w_hold;
            r_gnt   <= (w_state == GRANT) ? (4'b1 << w_s) : 4'd0;
            r_valid <= (r_state == GRANT);
            if (r_state == GRANT)
                r_y <= (r_s == 2'd0) ? bus.A : (r_s == 2'd1) ? bus.B : (r_s == 2'd2) ? bus.C : bus.D;
        end
    end
    assign bus.gnt   = r_gnt;
    assign bus.S     = r_s;
    assign bus.Y     = r_y;
    assign bus.valid = r_valid;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed and randomized checks of two arbiters (MAX_HOLD 4 and 1) against a rule-level model
module tb_rr_mux_arbiter;
    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [3:0] req = 4'd0;
    logic [3:0] dat [4];
    int n_vec = 0;
    int n_err = 0;
    int m_own [2];
    int m_hold [2];
    int m_last [2];
    int m_s [2];
    int m_y [2];
    bit m_v [2];
    int mh [2] = '{4, 1};

    always #5 clk = ~clk;

    rr_mux_arbiter_if #(.N(4)) bus4 ();
    rr_mux_arbiter_if #(.N(4)) bus1 ();
    assign bus4.req = req;
    assign bus4.A = dat[0];
    assign bus4.B = dat[1];
    assign bus4.C = dat[2];
    assign bus4.D = dat[3];
    assign bus1.req = req;
    assign bus1.A = dat[0];
    assign bus1.B = dat[1];
    assign bus1.C = dat[2];
    assign bus1.D = dat[3];

    rr_mux_arbiter #(.N(4), .MAX_HOLD(4)) dut4 (.clk(clk), .nrst(nrst), .bus(bus4));
    rr_mux_arbiter #(.N(4), .MAX_HOLD(1)) dut1 (.clk(clk), .nrst(nrst), .bus(bus1));

    function automatic int pick(int last, logic [3:0] r);
        for (int k = 1; k <= 4; k++)
            if (r[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_own[i] = -1; m_hold[i] = 0; m_last[i] = 3; m_s[i] = 0; m_y[i] = 0; m_v[i] = 0;
        end
    endtask

    // One clock edge for both the DUTs and the model; returns 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            int p;
            int o;
            bit others;
            o = m_own[i];
            p = pick(m_last[i], req);
            others = (o >= 0) && ((req & ~(4'b1 << o)) != 4'd0);
            m_v[i] = (o >= 0);
            if (o >= 0) m_y[i] = int'(dat[o]);
            if (o < 0) begin
                if (req != 4'd0) begin m_own[i] = p; m_s[i] = p; m_last[i] = p; m_hold[i] = 1; end
            end else if (!req[o] && others) begin
                m_own[i] = p; m_s[i] = p; m_last[i] = p; m_hold[i] = 1;
            end else if (!req[o]) begin
                m_own[i] = -1;
            end else if (m_hold[i] == mh[i] && others) begin
                m_own[i] = p; m_s[i] = p; m_last[i] = p; m_hold[i] = 1;
            end else if (m_hold[i] == mh[i]) begin
                m_hold[i] = 1;
            end else begin
                m_hold[i] = m_hold[i] + 1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        req = 4'd0;
        nrst = 1'b0;
        #2;
        nrst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        req = 4'hF;
        dat = '{4'd1, 4'd2, 4'd3, 4'd4};
        repeat (3) step();
        #2 nrst = 1'b0;
        #1;
        n_vec++;
        if ({bus4.gnt, bus4.S, bus4.Y, bus4.valid} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_async4 got=%h want=000", {bus4.gnt, bus4.S, bus4.Y, bus4.valid});
        end
        n_vec++;
        if ({bus1.gnt, bus1.S, bus1.Y, bus1.valid} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_async1 got=%h want=000", {bus1.gnt, bus1.S, bus1.Y, bus1.valid});
        end
        req = 4'd0;
        #1 nrst = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            step();
            n_vec++;
            if ({bus4.gnt, bus4.S, bus4.Y, bus4.valid} !== 11'd0) begin
                n_err++;
                $display("FAIL reset_idle cyc=%0d got=%h want=000", k, {bus4.gnt, bus4.S, bus4.Y, bus4.valid});
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        dat = '{4'd7, 4'd5, 4'b0010, 4'd9};
        req = 4'b0100;
        step();
        n_vec++;
        if ({bus4.gnt, bus4.S, bus4.valid} !== {4'b0100, 2'd2, 1'b0}) begin
            n_err++;
            $display("FAIL single_grant got=%b want=0100_10_0", {bus4.gnt, bus4.S, bus4.valid});
        end
        step();
        n_vec++;
        if ({bus4.gnt, bus4.S, bus4.Y, bus4.valid} !== {4'b0100, 2'd2, 4'b0010, 1'b1}) begin
            n_err++;
            $display("FAIL single_data got=%b want=0100_10_0010_1", {bus4.gnt, bus4.S, bus4.Y, bus4.valid});
        end
        for (int k = 0; k < 6; k++) begin
            step();
            n_vec++;
            if (bus4.gnt !== 4'b0100) begin
                n_err++;
                $display("FAIL single_keep cyc=%0d got=%b want=0100", k, bus4.gnt);
            end
        end
    endtask

    task automatic test_all();
        logic [3:0] exp;
        do_reset();
        dat = '{4'd1, 4'd2, 4'd3, 4'd4};
        req = 4'hF;
        for (int k = 1; k <= 20; k++) begin
            step();
            exp = 4'b1 << (((k - 1) / 4) % 4);
            n_vec++;
            if (bus4.gnt !== exp) begin
                n_err++;
                $display("FAIL all_order cyc=%0d got=%b want=%b", k, bus4.gnt, exp);
            end
        end
    endtask

    task automatic test_early();
        logic [3:0] exp [7] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000};
        do_reset();
        req = 4'b1011;
        for (int k = 0; k < 7; k++) begin
            if (k == 2) req = 4'b1010;
            step();
            n_vec++;
            if (bus4.gnt !== exp[k]) begin
                n_err++;
                $display("FAIL early_release cyc=%0d got=%b want=%b", k, bus4.gnt, exp[k]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] exp [3] = '{4'b1000, 4'b0000, 4'b0001};
        logic [3:0] rq [3] = '{4'b1000, 4'b0000, 4'b1001};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            req = rq[k];
            step();
            n_vec++;
            if (bus4.gnt !== exp[k]) begin
                n_err++;
                $display("FAIL wrap cyc=%0d got=%b want=%b", k, bus4.gnt, exp[k]);
            end
        end
    endtask

    task automatic test_hold1();
        logic [3:0] eg;
        logic [3:0] ey;
        do_reset();
        dat = '{4'd5, 4'd0, 4'd9, 4'd0};
        req = 4'b0101;
        for (int k = 1; k <= 8; k++) begin
            step();
            eg = (k % 2 == 1) ? 4'b0001 : 4'b0100;
            n_vec++;
            if (bus1.gnt !== eg) begin
                n_err++;
                $display("FAIL hold1_gnt cyc=%0d got=%b want=%b", k, bus1.gnt, eg);
            end
            if (k >= 2) begin
                ey = (k % 2 == 0) ? 4'd5 : 4'd9;
                n_vec++;
                if ({bus1.Y, bus1.valid} !== {ey, 1'b1}) begin
                    n_err++;
                    $display("FAIL hold1_data cyc=%0d got=%h/%b want=%h/1", k, bus1.Y, bus1.valid, ey);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [10:0] got;
        logic [10:0] exp;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(3) == 0) req = 4'($urandom_range(15));
            for (int j = 0; j < 4; j++) dat[j] = 4'($urandom_range(15));
            step();
            for (int i = 0; i < 2; i++) begin
                got = (i == 0) ? {bus4.gnt, bus4.S, bus4.Y, bus4.valid} : {bus1.gnt, bus1.S, bus1.Y, bus1.valid};
                exp = {(m_own[i] < 0) ? 4'd0 : 4'(4'b1 << m_own[i]), 2'(m_s[i]), 4'(m_y[i]), m_v[i]};
                n_vec++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL random dut=%0d cyc=%0d got{gnt,S,Y,valid}=%b want=%b", i, k, got, exp);
                end
            end
        end
    endtask

    initial begin
        dat = '{4'd0, 4'd0, 4'd0, 4'd0};
        model_reset();
        test_reset();
        test_single();
        test_all();
        test_early();
        test_wrap();
        test_hold1();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
